// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Operands are captured raw at accept. One PREP cycle takes magnitudes and resolves
// the divide-by-zero / signed-overflow cases. XLEN/UNROLL CALC cycles then run
// shift-add (multiply) or restoring shift-subtract (divide), and the result sits in
// DONE until the consumer takes it.
//
// state | meaning
// IDLE  | no op in flight, ready for a request
// PREP  | operands captured; form magnitudes/signs or resolve a special case
// CALC  | iterate UNROLL bits per cycle; last cycle applies sign fix-up
// DONE  | result valid, waiting for out_ready_i

module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_data_o,
    output logic            busy_o
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    generate
        if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4) || (UNROLL == 8)) ||
            ((XLEN % UNROLL) != 0)) begin : g_bad_unroll
            $error("ex_muldiv: UNROLL must be 1, 2, 4 or 8 and divide XLEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic              accept;
    logic              is_div;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res;
    logic [2*XLEN-1:0] acc_n;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix;
    logic [XLEN-1:0]   calc_res;

    assign in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
    assign accept      = in_valid_i & in_ready_o & ~flush_i;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_data_o  = data_q;

    // Operand signedness, magnitudes and the no-iteration divide cases.
    always_comb begin
        is_div   = op_q[2];
        a_sgn    = is_div ? ~op_q[0] : (op_q[1:0] != 2'b11);
        b_sgn    = is_div ? ~op_q[0] : ~op_q[1];
        a_neg    = a_sgn & a_q[XLEN-1];
        b_neg    = b_sgn & b_q[XLEN-1];
        a_mag    = a_neg ? (-a_q) : a_q;
        b_mag    = b_neg ? (-b_q) : b_q;
        div_zero = (b_q == '0);
        div_ovf  = ~op_q[0] & (a_q == MIN_NEG) & (b_q == '1);
        special  = is_div & (div_zero | div_ovf);
        if (div_zero) begin
            spec_res = op_q[1] ? a_q : '1;
        end else begin
            spec_res = op_q[1] ? '0 : a_q;
        end
    end

    // UNROLL iteration steps and the final sign fix-up of the result.
    always_comb begin
        logic [XLEN:0]   rr;
        logic            ge;
        logic [XLEN:0]   sum;
        logic [2*XLEN:0] sh;
        acc_n = acc_q;
        rr    = '0;
        ge    = 1'b0;
        sum   = '0;
        sh    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div) begin
                rr = {acc_n[2*XLEN-1:XLEN], acc_n[XLEN-1]};
                ge = (rr >= {1'b0, b_q});
                if (ge) begin
                    rr = rr - {1'b0, b_q};
                end
                acc_n = {rr[XLEN-1:0], acc_n[XLEN-2:0], ge};
            end else begin
                sum   = {1'b0, acc_n[2*XLEN-1:XLEN]} + (acc_n[0] ? {1'b0, b_q} : '0);
                sh    = {sum, acc_n[XLEN-1:0]};
                acc_n = sh[2*XLEN:1];
            end
        end
        prod    = negq_q ? (-acc_n) : acc_n;
        quo     = acc_n[XLEN-1:0];
        rem     = acc_n[2*XLEN-1:XLEN];
        quo_fix = negq_q ? (-quo) : quo;
        rem_fix = negr_q ? (-rem) : rem;
        if (is_div) begin
            calc_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath register update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = funct3_i;
                    a_d     = in1_i;
                    b_d     = in2_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (special) begin
                    data_d  = spec_res;
                    state_d = S_DONE;
                end else begin
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    b_d     = b_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    cnt_d   = CW'(N);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    data_d  = calc_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    op_d    = funct3_i;
                    a_d     = in1_i;
                    b_d     = in2_i;
                    state_d = S_PREP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: one instance with UNROLL=1 and one with UNROLL=4, exercised
// in turn against an arithmetic reference of the RV32M rules.

module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [2:0]  funct3    [2];
    logic [31:0] in1       [2];
    logic [31:0] in2       [2];
    logic        flush     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .UNROLL(1)) u_md1 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .funct3_i(funct3[0]), .in1_i(in1[0]), .in2_i(in2[0]),
        .flush_i(flush[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .busy_o(busy[0])
    );

    ex_muldiv #(.XLEN(32), .UNROLL(4)) u_md4 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .funct3_i(funct3[1]), .in1_i(in1[1]), .in2_i(in2[1]),
        .flush_i(flush[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .busy_o(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int iters(input int u);
        return (u == 0) ? 32 : 8;
    endfunction

    function automatic string nm(input int u, input string tag);
        return $sformatf("u%0d %s", (u == 0) ? 1 : 4, tag);
    endfunction

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          sp;
        longint unsigned up;
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Count edges from accept until out_valid is seen on a negedge sample.
    task automatic wait_valid(input int u, output int lat, output bit wait_ok);
        lat     = 0;
        wait_ok = 1'b1;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid[u] === 1'b1) break;
            if (busy[u] !== 1'b1 || in_ready[u] !== 1'b0) wait_ok = 1'b0;
        end
    endtask

    task automatic do_op(input int u, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input string tag);
        logic [31:0] exp;
        int          lat_exp;
        int          lat;
        bit          wait_ok;
        exp     = ref_op(f3, a, b);
        lat_exp = is_special(f3, a, b) ? 1 : iters(u) + 1;
        @(negedge clk);
        funct3[u]    = f3;
        in1[u]       = a;
        in2[u]       = b;
        in_valid[u]  = 1'b1;
        out_ready[u] = (hold == 0);
        chk(nm(u, {tag, " in_ready"}), 32'(in_ready[u]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        funct3[u]   = 3'($urandom);
        in1[u]      = $urandom;
        in2[u]      = $urandom;
        wait_valid(u, lat, wait_ok);
        chk(nm(u, {tag, " latency"}), 32'(lat), 32'(lat_exp));
        chk(nm(u, {tag, " busy/in_ready while calc"}), 32'(wait_ok), 32'd1);
        chk(nm(u, {tag, " data"}), out_data[u], exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk(nm(u, {tag, " held data"}), out_data[u], exp);
            chk(nm(u, {tag, " held valid/in_ready"}), {30'b0, out_valid[u], in_ready[u]}, 32'b10);
        end
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(nm(u, {tag, " consumed valid/busy"}), {30'b0, out_valid[u], busy[u]}, 32'b0);
    endtask

    task automatic b2b(input int u, input logic [2:0] f3a, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [2:0] f3b, input logic [31:0] a2,
                       input logic [31:0] b2);
        int lat;
        bit wait_ok;
        @(negedge clk);
        funct3[u] = f3a; in1[u] = a1; in2[u] = b1;
        in_valid[u] = 1'b1; out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        funct3[u] = f3b; in1[u] = a2; in2[u] = b2;
        wait_valid(u, lat, wait_ok);
        chk(nm(u, "b2b first data"), out_data[u], ref_op(f3a, a1, b1));
        chk(nm(u, "b2b in_ready in done"), 32'(in_ready[u]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        @(negedge clk);
        chk(nm(u, "b2b no bubble valid/busy"), {30'b0, out_valid[u], busy[u]}, 32'b01);
        lat = 0;
        while (lat < 100 && out_valid[u] !== 1'b1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk(nm(u, "b2b second latency"), 32'(lat), 32'(iters(u) + 1));
        chk(nm(u, "b2b second data"), out_data[u], ref_op(f3b, a2, b2));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic flush_calc(input int u);
        bit rose;
        @(negedge clk);
        funct3[u] = 3'd0; in1[u] = 32'h1234_5678; in2[u] = 32'h0000_0099;
        in_valid[u] = 1'b1; out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        repeat ((u == 0) ? 11 : 4) @(posedge clk);
        @(negedge clk);
        flush[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[u] = 1'b0;
        chk(nm(u, "flush calc valid/busy/in_ready"),
            {29'b0, out_valid[u], busy[u], in_ready[u]}, 32'b001);
        rose = 1'b0;
        repeat (iters(u) + 5) begin
            @(negedge clk);
            if (out_valid[u] !== 1'b0) rose = 1'b1;
        end
        chk(nm(u, "flush calc out_valid stays low"), 32'(rose), 32'd0);
    endtask

    task automatic flush_done(input int u);
        int lat;
        bit wait_ok;
        @(negedge clk);
        funct3[u] = 3'd5; in1[u] = 32'd100; in2[u] = 32'd7;
        in_valid[u] = 1'b1; out_ready[u] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        wait_valid(u, lat, wait_ok);
        chk(nm(u, "flush done reached"), 32'(out_valid[u]), 32'd1);
        flush[u] = 1'b1; out_ready[u] = 1'b1; in_valid[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[u] = 1'b0; in_valid[u] = 1'b0;
        chk(nm(u, "flush done valid/busy"), {30'b0, out_valid[u], busy[u]}, 32'b0);
    endtask

    task automatic reset_mid(input int u);
        @(negedge clk);
        funct3[u] = 3'd4; in1[u] = 32'hDEAD_BEEF; in2[u] = 32'd3;
        in_valid[u] = 1'b1; out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(nm(u, "reset mid valid/busy"), {30'b0, out_valid[u], busy[u]}, 32'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(nm(u, "reset mid in_ready"), 32'(in_ready[u]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0; funct3[u] = '0; in1[u] = '0; in2[u] = '0;
            flush[u] = 1'b0; out_ready[u] = 1'b1;
        end
        #3;
        for (int u = 0; u < 2; u++) begin
            chk(nm(u, "reset valid/busy"), {30'b0, out_valid[u], busy[u]}, 32'b0);
            chk(nm(u, "reset out_data"), out_data[u], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) chk(nm(u, "in_ready after reset"), 32'(in_ready[u]), 32'd1);

        for (int u = 0; u < 2; u++) begin
            do_op(u, 3'd0, 32'd7,         32'hFFFF_FFFD, 0, "MUL 7*-3");
            do_op(u, 3'd1, 32'h8000_0000, 32'h8000_0000, 0, "MULH min*min");
            do_op(u, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MULHU max*max");
            do_op(u, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "MULHSU -1*max");
            do_op(u, 3'd5, 32'd5,         32'd0,         0, "DIVU 5/0");
            do_op(u, 3'd6, 32'd5,         32'd0,         0, "REM 5/0");
            do_op(u, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "DIV ovf");
            do_op(u, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "REM ovf");
            do_op(u, 3'd4, 32'hFFFF_FFF9, 32'd2,         5, "DIV -7/2");
            do_op(u, 3'd6, 32'hFFFF_FFF9, 32'd2,         5, "REM -7/2");
            b2b(u, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 32'hFFFF_0001, 32'd13);
            flush_calc(u);
            flush_done(u);
            reset_mid(u);
            for (int i = 0; i < 30; i++) begin
                logic [2:0]  f3;
                logic [31:0] a;
                logic [31:0] b;
                f3 = 3'($urandom_range(0, 7));
                a  = pick_operand();
                b  = pick_operand();
                do_op(u, f3, a, b, $urandom_range(0, 2), $sformatf("rand%0d f%0d", i, f3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
